fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- IF-stage front end. Owns the PC register and the instruction-cache request handshake.
- Produces the `instr_mem_resp` qualifier consumed by `stall_control_unit`, plus the PC/instruction pair loaded into IF/ID.
- Consumes `load_pc` and branch/jump redirects from downstream.
- Hides wrong-path responses and stalled-pipeline re-presentation from the rest of the pipeline.

Parameters:
- RESET_PC, 32'h0000_0060, PC value loaded on reset.
- XLEN, 32, address/instruction width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- load_pc  in  1  from stall control; 1 = pipeline may advance past IF.
- pc_redirect  in  1  taken branch / jal / jalr resolved this cycle.
- redirect_target  in  XLEN  target PC; valid when `pc_redirect`=1.
- imem_address  out  XLEN  I-cache request address.
- imem_read  out  1  I-cache read request.
- imem_resp  in  1  I-cache response; data valid this cycle.
- imem_rdata  in  XLEN  I-cache read data.
- instr_mem_resp  out  1  valid instruction presented this cycle (to stall control).
- fetch_pc  out  XLEN  PC of presented instruction (to IF/ID).
- fetch_instr  out  XLEN  presented instruction (to IF/ID).

Behaviour:
- States (`fetch_state_t`):
  - FETCH: request outstanding.
  - HOLD: instruction buffered, pipeline stalled.
  - DISCARD: outstanding request is wrong-path.
- Registers: `pc_q`, `pend_q` (pending target), `buf_q` (held instruction), `state_q`.
- Reset: `pc_q`=RESET_PC, `state_q`=FETCH, `pend_q`=0, `buf_q`=0.
  - During the rst cycle: `imem_read`=0, `instr_mem_resp`=0, `fetch_instr`=0.
  - The first request is issued the cycle after rst deasserts.
  - Reset mid-request abandons the request; the cache is reset together with the core.
- Request stability: `imem_address`=`pc_q` and `imem_read`=1 in FETCH and DISCARD. Address never changes while a request is outstanding.
- Latency: a response may arrive in the same cycle `imem_read` first rises (hit) or any later cycle. No cap on latency.
- FETCH transitions:
  - `imem_resp`=1, no redirect, `load_pc`=1: `instr_mem_resp`=1, `fetch_instr`=`imem_rdata`, `fetch_pc`=`pc_q`; `pc_q`<=`pc_q`+4; stay in FETCH.
  - `imem_resp`=1, no redirect, `load_pc`=0 (data-cache or hazard stall): `instr_mem_resp`=1; `buf_q`<=`imem_rdata`; go to HOLD; `pc_q` unchanged.
  - `imem_resp`=1 and `pc_redirect`=1: response is wrong-path; `instr_mem_resp`=0; `pc_q`<=`redirect_target`; stay in FETCH.
  - `imem_resp`=0 and `pc_redirect`=1: `pend_q`<=`redirect_target`; go to DISCARD.
  - `imem_resp`=0, no redirect: `instr_mem_resp`=0; hold.
- HOLD transitions:
  - Outputs: `imem_read`=0; `instr_mem_resp`=1; `fetch_instr`=`buf_q`; `fetch_pc`=`pc_q`.
  - `pc_redirect`=1: drop buffer; `instr_mem_resp`=0; `pc_q`<=target; go to FETCH.
  - Else `load_pc`=1: `pc_q`<=`pc_q`+4; go to FETCH.
  - Else stay in HOLD.
- DISCARD transitions:
  - `instr_mem_resp`=0 always.
  - `pc_redirect`=1: `pend_q`<=`redirect_target` (newest redirect wins).
  - On `imem_resp`: `pc_q`<=`pend_q` (or `redirect_target` if redirect arrives the same cycle); go to FETCH.
- Precedence:
  - Redirect is captured regardless of `load_pc`. Stall control keeps ID/EX advancing during I-miss, so a redirect is never presented twice.
  - Redirect beats `load_pc` beats sequential advance.
- Arithmetic: PC+4 is modulo 2^XLEN; wrap from 0xFFFF_FFFC to 0 is silent.
- `redirect_target` low bits are not checked; misalignment is passed through.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Enabled:
  - Adds 32-bit outputs `perf_miss_cycles`, `perf_discards`, `perf_hold_cycles`, all reset to 0, saturating at 0xFFFF_FFFF.
  - `perf_miss_cycles` increments on each FETCH/DISCARD cycle with `imem_resp`=0.
  - `perf_discards` increments on each dropped response: FETCH+resp+redirect, DISCARD+resp, HOLD+redirect.
  - `perf_hold_cycles` increments on each HOLD cycle.
- Disabled: ports and counters absent; functional behaviour identical.

Decomposition:
- `fetch_state_t` enum and `RV32I_INSTR_BYTES`=4 go in `rv32i_types`.
- Counters form the natural sub-module `fetch_perf_counters`, instantiated only under FETCH_PERF_EN.
- The FSM and datapath stay in `fetch_unit`.

Test Plan:
- Reset, then `imem_resp` held 1, `load_pc`=1 → addresses 0x60, 0x64, 0x68 on consecutive cycles, `instr_mem_resp`=1 each cycle.
- Miss: `imem_resp` low 5 cycles at 0x64 → `imem_address` stable at 0x64, `instr_mem_resp`=0 for 5 cycles, then 1; next address 0x68.
- Redirect to 0x200 during miss at 0x64, resp 3 cycles later → response dropped, next request 0x200; with perf enabled, `perf_discards`=1.
- Redirect to 0x300, then 0x400 while in DISCARD → first post-discard request is 0x400.
- Resp at 0x70 with `load_pc`=0 for 4 cycles → `instr_mem_resp`=1, `fetch_instr` stable, `imem_read`=0; on `load_pc`=1 next address 0x74.
- rst asserted mid-miss at 0x88 → next cycle `imem_address`=0x60, state FETCH; stale `imem_resp` in the rst cycle is ignored.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: fetch-unit local constants and helpers.
//   DEFAULT_RESET_PC : PC loaded on reset unless overridden
//   PERF_CNT_W       : width of the optional performance counters
//   sat_inc()        : saturating increment used by the counters
package fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0060;
    localparam int unsigned PERF_CNT_W       = 32;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rv32i_types.sv
// rv32i_types: types and constants shared by the RV32I core blocks.
//   fetch_state_t     : IF-stage front-end state (FETCH / HOLD / DISCARD)
//   RV32I_INSTR_BYTES : size of one instruction in bytes (sequential PC step)
package rv32i_types;

    localparam int unsigned RV32I_INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,   // request outstanding
        HOLD    = 2'd1,   // instruction buffered, pipeline stalled
        DISCARD = 2'd2    // outstanding request is wrong-path
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-cache request/response bundle.
//   imem_address : request address        (fetch -> cache)
//   imem_read    : read request            (fetch -> cache)
//   imem_resp    : response valid          (cache -> fetch)
//   imem_rdata   : response data           (cache -> fetch)
// Modports: master = fetch side, slave = cache side.
interface fetch_unit_if #(
    parameter int unsigned XLEN = 32
) ();

    logic [XLEN-1:0] imem_address;
    logic            imem_read;
    logic            imem_resp;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_address,
        output imem_read,
        input  imem_resp,
        input  imem_rdata
    );

    modport slave (
        input  imem_address,
        input  imem_read,
        output imem_resp,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_perf_counters.sv
// fetch_perf_counters: saturating event counters for the fetch unit.
// Present only when FETCH_PERF_EN is defined.
//   clk, rst            : clock, synchronous active-high reset
//   miss_evt_i          : request outstanding with no response this cycle
//   discard_evt_i       : a response/buffered instruction was dropped
//   hold_evt_i          : fetch unit holding a buffered instruction
//   perf_*_o            : counter values, saturating at all-ones
`ifdef FETCH_PERF_EN
module fetch_perf_counters
    import fetch_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_evt_i,
    input  logic                  discard_evt_i,
    input  logic                  hold_evt_i,
    output logic [PERF_CNT_W-1:0] perf_miss_cycles_o,
    output logic [PERF_CNT_W-1:0] perf_discards_o,
    output logic [PERF_CNT_W-1:0] perf_hold_cycles_o
);

    logic [PERF_CNT_W-1:0] miss_q, miss_d;
    logic [PERF_CNT_W-1:0] disc_q, disc_d;
    logic [PERF_CNT_W-1:0] hold_q, hold_d;

    always_comb begin
        miss_d = miss_evt_i    ? sat_inc(miss_q) : miss_q;
        disc_d = discard_evt_i ? sat_inc(disc_q) : disc_q;
        hold_d = hold_evt_i    ? sat_inc(hold_q) : hold_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_q <= '0;
            disc_q <= '0;
            hold_q <= '0;
        end else begin
            miss_q <= miss_d;
            disc_q <= disc_d;
            hold_q <= hold_d;
        end
    end

    assign perf_miss_cycles_o = miss_q;
    assign perf_discards_o    = disc_q;
    assign perf_hold_cycles_o = hold_q;

endmodule
`endif

// File: rtl/fetch_unit.sv
// fetch_unit: IF-stage front end. Owns the PC, drives the I-cache request
// handshake, hides wrong-path responses and re-presents a buffered
// instruction while the pipeline is stalled.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   load_pc           : pipeline may advance past IF
//   pc_redirect       : taken branch / jal / jalr this cycle
//   redirect_target   : redirect PC (low bits passed through unchecked)
//   imem              : fetch_unit_if.master (I-cache request/response)
//   instr_mem_resp    : valid instruction presented this cycle
//   fetch_pc          : PC of presented instruction
//   fetch_instr       : presented instruction
// Optional (macro FETCH_PERF_EN): perf_miss_cycles, perf_discards,
//   perf_hold_cycles saturating 32-bit event counters.
module fetch_unit
    import rv32i_types::*;
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_pc,
    input  logic                  pc_redirect,
    input  logic [XLEN-1:0]       redirect_target,
    fetch_unit_if.master          imem,
    output logic                  instr_mem_resp,
    output logic [XLEN-1:0]       fetch_pc,
    output logic [XLEN-1:0]       fetch_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_miss_cycles,
    output logic [PERF_CNT_W-1:0] perf_discards,
    output logic [PERF_CNT_W-1:0] perf_hold_cycles
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic [XLEN-1:0] pc_seq;
    logic            read_c;
    logic            valid_c;
    logic [XLEN-1:0] instr_c;

    // Sequential advance wraps silently modulo 2^XLEN.
    assign pc_seq = pc_q + XLEN'(RV32I_INSTR_BYTES);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        buf_d   = buf_q;
        read_c  = 1'b0;
        valid_c = 1'b0;
        instr_c = imem.imem_rdata;

        unique case (state_q)
            FETCH: begin
                read_c = 1'b1;
                if (imem.imem_resp) begin
                    if (pc_redirect) begin
                        // Response belongs to the wrong path: drop it.
                        pc_d = redirect_target;
                    end else begin
                        valid_c = 1'b1;
                        if (load_pc) begin
                            pc_d = pc_seq;
                        end else begin
                            buf_d   = imem.imem_rdata;
                            state_d = HOLD;
                        end
                    end
                end else if (pc_redirect) begin
                    // Address must stay stable until the cache answers, so
                    // the target waits in pend_q while the reply is discarded.
                    pend_d  = redirect_target;
                    state_d = DISCARD;
                end
            end
            HOLD: begin
                instr_c = buf_q;
                if (pc_redirect) begin
                    pc_d    = redirect_target;
                    state_d = FETCH;
                end else begin
                    valid_c = 1'b1;
                    if (load_pc) begin
                        pc_d    = pc_seq;
                        state_d = FETCH;
                    end
                end
            end
            DISCARD: begin
                read_c = 1'b1;
                if (pc_redirect) begin
                    pend_d = redirect_target;
                end
                if (imem.imem_resp) begin
                    pc_d    = pc_redirect ? redirect_target : pend_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Nothing is requested or presented during the reset cycle.
        if (rst) begin
            read_c  = 1'b0;
            valid_c = 1'b0;
            instr_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            buf_q   <= buf_d;
        end
    end

    assign imem.imem_address = pc_q;
    assign imem.imem_read    = read_c;
    assign instr_mem_resp    = valid_c;
    assign fetch_pc          = pc_q;
    assign fetch_instr       = instr_c;

`ifdef FETCH_PERF_EN
    logic miss_evt;
    logic discard_evt;
    logic hold_evt;

    assign miss_evt    = !rst && (state_q != HOLD) && !imem.imem_resp;
    assign discard_evt = !rst && (((state_q == FETCH) && imem.imem_resp && pc_redirect) ||
                                  ((state_q == DISCARD) && imem.imem_resp) ||
                                  ((state_q == HOLD) && pc_redirect));
    assign hold_evt    = !rst && (state_q == HOLD);

    fetch_perf_counters u_perf (
        .clk                (clk),
        .rst                (rst),
        .miss_evt_i         (miss_evt),
        .discard_evt_i      (discard_evt),
        .hold_evt_i         (hold_evt),
        .perf_miss_cycles_o (perf_miss_cycles),
        .perf_discards_o    (perf_discards),
        .perf_hold_cycles_o (perf_hold_cycles)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic for fetch_unit,
// checked every cycle against a behavioural model of the fetch front end.
// Optional counters are checked when FETCH_PERF_EN is defined.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_pc = 1'b0;
    logic        pc_redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        instr_mem_resp;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_miss_cycles;
    logic [31:0] perf_discards;
    logic [31:0] perf_hold_cycles;
`endif

    fetch_unit_if #(.XLEN(32)) bif ();

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0060)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .load_pc         (load_pc),
        .pc_redirect     (pc_redirect),
        .redirect_target (redirect_target),
        .imem            (bif.master),
        .instr_mem_resp  (instr_mem_resp),
        .fetch_pc        (fetch_pc),
        .fetch_instr     (fetch_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_miss_cycles (perf_miss_cycles),
        .perf_discards    (perf_discards),
        .perf_hold_cycles (perf_hold_cycles)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: the next address to fetch, whether an instruction is
    // parked waiting for the pipeline, and whether the request in flight is
    // known to be wrong-path (with the address to resume from).
    logic [31:0] m_pc      = 32'h60;
    logic        m_parked  = 1'b0;
    logic [31:0] m_parked_instr = '0;
    logic        m_wrong   = 1'b0;
    logic [31:0] m_resume  = '0;
    int unsigned m_miss    = 0;
    int unsigned m_disc    = 0;
    int unsigned m_hold    = 0;
    logic [31:0] last_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    // One clock cycle: drive inputs, compare all meaningful outputs against
    // the model, then advance the model past the coming clock edge.
    task automatic step(input logic r, input logic l, input logic rd,
                        input logic [31:0] tg, input logic rs);
        logic        exp_read;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] rdata;
        @(posedge clk);
        #1;
        rdata           = $urandom;
        rst             = r;
        load_pc         = l;
        pc_redirect     = rd;
        redirect_target = tg;
        bif.imem_resp   = rs;
        bif.imem_rdata  = rdata;
        last_rdata      = rdata;
        #1;

`ifdef FETCH_PERF_EN
        chk("perf_miss_cycles", perf_miss_cycles, 32'(m_miss));
        chk("perf_discards",    perf_discards,    32'(m_disc));
        chk("perf_hold_cycles", perf_hold_cycles, 32'(m_hold));
`endif

        if (r) begin
            exp_read  = 1'b0;
            exp_valid = 1'b0;
            exp_instr = '0;
        end else if (m_parked) begin
            exp_read  = 1'b0;
            exp_valid = !rd;
            exp_instr = m_parked_instr;
        end else begin
            exp_read  = 1'b1;
            exp_valid = !m_wrong && rs && !rd;
            exp_instr = rdata;
        end

        chk("imem_read", 32'(bif.imem_read), 32'(exp_read));
        if (exp_read) chk("imem_address", bif.imem_address, m_pc);
        chk("instr_mem_resp", 32'(instr_mem_resp), 32'(exp_valid));
        if (exp_valid) begin
            chk("fetch_pc", fetch_pc, m_pc);
            chk("fetch_instr", fetch_instr, exp_instr);
        end
        if (r) chk("fetch_instr_rst", fetch_instr, 32'h0);

        if (r) begin
            m_pc = 32'h60; m_parked = 1'b0; m_wrong = 1'b0; m_resume = '0;
            m_miss = 0; m_disc = 0; m_hold = 0;
        end else if (m_parked) begin
            m_hold = sat(m_hold);
            if (rd) begin
                m_disc = sat(m_disc);
                m_pc = tg; m_parked = 1'b0;
            end else if (l) begin
                m_pc = m_pc + 32'd4; m_parked = 1'b0;
            end
        end else begin
            if (!rs) m_miss = sat(m_miss);
            if (m_wrong) begin
                if (rs) begin
                    m_disc = sat(m_disc);
                    m_pc = rd ? tg : m_resume;
                    m_wrong = 1'b0;
                end else if (rd) begin
                    m_resume = tg;
                end
            end else if (rs) begin
                if (rd) begin
                    m_disc = sat(m_disc);
                    m_pc = tg;
                end else if (l) begin
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_parked = 1'b1; m_parked_instr = rdata;
                end
            end else if (rd) begin
                m_wrong = 1'b1; m_resume = tg;
            end
        end
    endtask

    initial begin : main
        logic [31:0] held;
        int unsigned lat;
        logic        r, l, rd, rs;
        logic [31:0] tg;

        bif.imem_resp  = 1'b0;
        bif.imem_rdata = '0;

        // Reset with a stale response present.
        step(1, 1, 0, 0, 1);
        chk("rst_read", 32'(bif.imem_read), 32'h0);
        chk("rst_valid", 32'(instr_mem_resp), 32'h0);

        // Back-to-back hits.
        step(0, 1, 0, 0, 1); chk("hit0_addr", bif.imem_address, 32'h60);
        chk("hit0_valid", 32'(instr_mem_resp), 32'h1);
        step(0, 1, 0, 0, 1); chk("hit1_addr", bif.imem_address, 32'h64);
        step(0, 1, 0, 0, 1); chk("hit2_addr", bif.imem_address, 32'h68);

        // Five-cycle miss at 0x6C.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0);
            chk("miss_addr", bif.imem_address, 32'h6C);
            chk("miss_valid", 32'(instr_mem_resp), 32'h0);
        end
        step(0, 1, 0, 0, 1); chk("miss_done_valid", 32'(instr_mem_resp), 32'h1);
        step(0, 1, 0, 0, 1); chk("after_miss_addr", bif.imem_address, 32'h70);

        // Redirect during a miss; the late response is dropped.
        step(0, 1, 1, 32'h200, 0);
        step(0, 1, 0, 0, 0); chk("discard_addr", bif.imem_address, 32'h74);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1); chk("discard_drop", 32'(instr_mem_resp), 32'h0);
        step(0, 1, 0, 0, 1); chk("redir_addr", bif.imem_address, 32'h200);

        // Newest redirect wins while discarding.
        step(0, 1, 1, 32'h300, 0);
        step(0, 1, 1, 32'h400, 0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1); chk("newest_redir", bif.imem_address, 32'h400);

        // Stall: instruction buffered and re-presented.
        step(0, 0, 0, 0, 1); held = last_rdata;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0);
            chk("hold_read", 32'(bif.imem_read), 32'h0);
            chk("hold_valid", 32'(instr_mem_resp), 32'h1);
            chk("hold_instr", fetch_instr, held);
        end
        step(0, 1, 0, 0, 0); chk("hold_release", fetch_instr, held);
        step(0, 1, 0, 0, 1); chk("post_hold_addr", bif.imem_address, 32'h408);

        // PC wrap and misaligned target pass-through.
        step(0, 1, 1, 32'hFFFF_FFFC, 1);
        step(0, 1, 0, 0, 1); chk("wrap_top", bif.imem_address, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 1); chk("wrap_zero", bif.imem_address, 32'h0);
        step(0, 1, 1, 32'h203, 1);
        step(0, 1, 0, 0, 0); chk("misaligned", bif.imem_address, 32'h203);

        // Reset mid-miss with a stale response.
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0); chk("post_rst_addr", bif.imem_address, 32'h60);
        chk("post_rst_read", 32'(bif.imem_read), 32'h1);

        // Redirect while holding drops the buffer.
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h500, 0); chk("hold_redir_valid", 32'(instr_mem_resp), 32'h0);
        step(0, 1, 0, 0, 0); chk("hold_redir_addr", bif.imem_address, 32'h500);

        // Randomized traffic with a variable-latency cache.
        lat = 0;
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            l  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 9))
                0:       tg = $urandom;
                1:       tg = 32'hFFFF_FFF8;
                default: tg = $urandom & 32'h0000_FFFC;
            endcase
            if (r) begin
                rs  = 1'($urandom_range(0, 1));
                lat = 0;
            end else if (m_parked) begin
                rs = 1'b0;
            end else if (lat == 0) begin
                rs  = 1'b1;
                lat = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
            end else begin
                rs  = 1'b0;
                lat = lat - 1;
            end
            step(r, l, rd, tg, rs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
